soc_region_map: RTL and testbench
=================================

# soc_region_map

Runtime-programmable address-region map for the SoC: a table of `NrRules` base/length rules, each with a target slave index and cached/execute/non-idempotent attributes. It takes a stream of physical addresses and returns, two cycles later, the routing and attribute decision. It sits between the core's fetch/LSU path and the AXI crossbar. It replaces compile-time region constants with a lockable, reset-initialised table.

## Interface
- `NrRules`, 8: number of region rules (1..16).
- `NrSlaves`, 3: number of crossbar slaves. Index `NrSlaves` is the error slave.
- `AddrWidth`, 64: address width.
- `Rule0Base`, 64'h8000_0000: reset base of rule 0 (DRAM).
- `Rule0Length`, 64'h4000_0000: reset length of rule 0.
- `Rule0Attr`, 16'h0007: reset attribute word of rule 0 (valid, cached, exec, slave 0).
- SW = $clog2(NrSlaves+1); IW = $clog2(NrRules).
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: asynchronous active-low reset.
- `cfg_we_i` in, 1: config write strobe.
- `cfg_idx_i` in, IW: rule index.
- `cfg_field_i` in, 2: 0 = base, 1 = length, 2 = attr, 3 = lock.
- `cfg_wdata_i` in, AddrWidth: write data.
- `cfg_err_o` out, 1: one-cycle pulse on a rejected write.
- `cfg_locked_o` out, 1: table locked.
- `req_valid_i` in, 1: lookup request valid.
- `req_ready_o` out, 1: lookup request ready.
- `req_addr_i` in, AddrWidth: lookup address.
- `rsp_valid_o` out, 1: response valid.
- `rsp_ready_i` in, 1: response ready.
- `rsp_hit_o` out, 1: a rule matched.
- `rsp_rule_o` out, IW: index of the winning rule.
- `rsp_slave_o` out, SW: target slave.
- `rsp_cached_o`, `rsp_exec_o`, `rsp_nonidem_o` out, 1 each: attributes of the winning rule.
- `miss_cnt_o` out, 16: count of misses.

## Operation
- Attribute word: bit0 valid, bit1 cached, bit2 exec, bit3 non-idempotent, bits[8+SW-1:8] slave. All other bits are ignored and read as 0.
- Reset state:
  - Rule 0 = Rule0Base / Rule0Length / Rule0Attr.
  - Rules 1..NrRules-1 have base, length and attr all set to 0 (invalid).
  - Unlocked.
  - All output-side state cleared.
- Match for rule i requires all of:
  - valid;
  - `addr >= base`;
  - `(addr - base) < length`, computed in AddrWidth bits with no overflow path.
  - A rule with length 0 never matches.
  - Base + length wrapping past 2^AddrWidth is not special-cased: the subtraction form is authoritative.
- Priority: the lowest matching index wins. Overlaps are legal.
- Miss response: hit = 0, rule = 0, slave = NrSlaves, cached = 0, exec = 0, nonidem = 1. `miss_cnt_o` increments when a miss response is accepted. It saturates at 16'hFFFF.
- Config writes:
  - A write applies at the clock edge of the cycle in which `cfg_we_i` is high.
  - field 3 with `wdata[0] = 1` sets lock. Lock is cleared only by reset.
  - A write is rejected (no state change, `cfg_err_o` pulses the next cycle) if it arrives while locked, or if `cfg_idx_i >= NrRules`. A field-3 write issued while already locked is also rejected.
- Pipeline stage S1 (accept):
  - On handshake, compares the address against all rules.
  - Captures hit, rule index and that rule's attribute word (snapshot).
- Pipeline stage S2 (output register): drives the `rsp_*` outputs from the S1 snapshot.
- Config consistency: a request accepted in cycle t sees the table as it was before any write in cycle t. Later writes never alter in-flight results.
- Flow control:
  - Each stage has a valid bit. A stage advances when the stage downstream of it is empty or draining in the same cycle.
  - `req_ready_o = !s1_valid | (!s2_valid | rsp_ready_i)`.
  - Full throughput is one lookup per cycle with `rsp_ready_i` held high.
  - The `rsp_*` outputs are stable while `rsp_valid_o & !rsp_ready_i`.

## Timing
- Latency: request accepted at edge t → `rsp_valid_o` high after edge t+1, i.e. two register stages with no stalls.
- Outputs reset to 0, with two exceptions: `rsp_slave_o` resets to NrSlaves and `rsp_nonidem_o` resets to 1.
- Reset mid-operation drops all in-flight lookups with no response, restores the reset table, and clears `miss_cnt_o`.
- When S1 and S2 are both full and `rsp_ready_i = 0`, `req_ready_o = 0`, and it rises in the same cycle `rsp_ready_i` rises.
- A config write in the same cycle as a request acceptance is legal. The request uses the old value.
- `cfg_err_o` is registered and is high for exactly one cycle per rejected write.

## Test plan
- After reset, lookup 0x8000_1000 → two cycles later hit = 1, rule = 0, slave = 0, cached = 1, exec = 1, nonidem = 0.
- After reset, lookup 0x0200_0000 → miss: slave = 3, nonidem = 1, and `miss_cnt_o` goes to 1.
- Program rule 1 as base 0x0200_0000, length 0xC0000, attr 0x0209. Check:
  - 0x020B_FFFF → rule 1, slave 2, nonidem 1.
  - 0x020C_0000 → miss.
- Overlap: program rule 1 as base 0x8000_0000, length 0x1000, attr 0x0101. Lookup 0x8000_0800 → rule 0 wins (lower index).
- Back-to-back stream of 8 requests with `rsp_ready_i` toggled randomly:
  - no response is lost or duplicated;
  - responses come out in order;
  - outputs stay stable while stalled.
  - A write to rule 0 attr issued in the same cycle as request 4 does not affect requests 1–4, and does affect request 5 onward.
- Lock handling:
  - Write lock, then write rule 2 base → `cfg_err_o` pulses once and the table is unchanged.
  - A write with `cfg_idx_i = NrRules` while unlocked also pulses `cfg_err_o`.
  - Asserting `rst_ni` low mid-stream clears lock, pipeline and counter.

Source files
------------

// File: rtl/soc_region_map.sv
// soc_region_map: lockable, reset-initialised base/length region table with a
// two-stage lookup pipeline returning routing and attribute decisions.
module soc_region_map #(
    parameter int unsigned          NrRules     = 8,
    parameter int unsigned          NrSlaves    = 3,
    parameter int unsigned          AddrWidth   = 64,
    parameter logic [AddrWidth-1:0] Rule0Base   = 64'h8000_0000,
    parameter logic [AddrWidth-1:0] Rule0Length = 64'h4000_0000,
    parameter logic [15:0]          Rule0Attr   = 16'h0007,
    localparam int unsigned         SW          = $clog2(NrSlaves + 1),
    localparam int unsigned         IW          = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_we_i,
    input  logic [IW-1:0]        cfg_idx_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_err_o,
    output logic                 cfg_locked_o,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_hit_o,
    output logic [IW-1:0]        rsp_rule_o,
    output logic [SW-1:0]        rsp_slave_o,
    output logic                 rsp_cached_o,
    output logic                 rsp_exec_o,
    output logic                 rsp_nonidem_o,
    output logic [15:0]          miss_cnt_o
);
    // Stored attribute keeps only meaningful bits: {slave, nonidem, exec, cached, valid}.
    localparam int unsigned   AW         = SW + 4;
    localparam logic [IW:0]   IdxLimit   = (IW + 1)'(NrRules);
    localparam logic [AW-1:0] Rule0AttrP = {Rule0Attr[8 +: SW], Rule0Attr[3:0]};

    logic [AddrWidth-1:0] base_q [NrRules];
    logic [AddrWidth-1:0] base_d [NrRules];
    logic [AddrWidth-1:0] len_q  [NrRules];
    logic [AddrWidth-1:0] len_d  [NrRules];
    logic [AW-1:0]        attr_q [NrRules];
    logic [AW-1:0]        attr_d [NrRules];
    logic                 lock_q, lock_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 wr_ok;

    always_comb begin
        wr_ok     = cfg_we_i && !lock_q && ({1'b0, cfg_idx_i} < IdxLimit);
        cfg_err_d = cfg_we_i && !wr_ok;
        lock_d    = lock_q | (wr_ok && (cfg_field_i == 2'd3) && cfg_wdata_i[0]);
        for (int unsigned i = 0; i < NrRules; i++) begin
            base_d[i] = base_q[i];
            len_d[i]  = len_q[i];
            attr_d[i] = attr_q[i];
            if (wr_ok && (cfg_idx_i == IW'(i))) begin
                case (cfg_field_i)
                    2'd0:    base_d[i] = cfg_wdata_i;
                    2'd1:    len_d[i]  = cfg_wdata_i;
                    2'd2:    attr_d[i] = {cfg_wdata_i[8 +: SW], cfg_wdata_i[3:0]};
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NrRules; g++) begin : g_rule
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                base_q[g] <= (g == 0) ? Rule0Base   : '0;
                len_q[g]  <= (g == 0) ? Rule0Length : '0;
                attr_q[g] <= (g == 0) ? Rule0AttrP  : '0;
            end else begin
                base_q[g] <= base_d[g];
                len_q[g]  <= len_d[g];
                attr_q[g] <= attr_d[g];
            end
        end
    end

    // Lowest matching index wins; the subtraction form defines the range check.
    logic          match_hit;
    logic [IW-1:0] match_rule;
    logic [AW-1:0] match_attr;

    always_comb begin
        match_hit  = 1'b0;
        match_rule = '0;
        match_attr = '0;
        for (int unsigned i = 0; i < NrRules; i++) begin
            if (!match_hit && attr_q[i][0] && (req_addr_i >= base_q[i])
                && ((req_addr_i - base_q[i]) < len_q[i])) begin
                match_hit  = 1'b1;
                match_rule = IW'(i);
                match_attr = attr_q[i];
            end
        end
    end

    logic          s1_valid_q, s1_valid_d;
    logic          s1_hit_q, s1_hit_d;
    logic [IW-1:0] s1_rule_q, s1_rule_d;
    logic [AW-1:0] s1_attr_q, s1_attr_d;
    logic          s2_valid_q, s2_valid_d;
    logic          s2_hit_q, s2_hit_d;
    logic [IW-1:0] s2_rule_q, s2_rule_d;
    logic [SW-1:0] s2_slave_q, s2_slave_d;
    logic          s2_cached_q, s2_cached_d;
    logic          s2_exec_q, s2_exec_d;
    logic          s2_nonidem_q, s2_nonidem_d;
    logic [15:0]   miss_cnt_q, miss_cnt_d;
    logic          s2_ready, s1_ready, accept, s1_move;

    always_comb begin
        s2_ready = !s2_valid_q || rsp_ready_i;
        s1_ready = !s1_valid_q || s2_ready;
        accept   = req_valid_i && s1_ready;
        s1_move  = s1_valid_q && s2_ready;

        s1_valid_d = accept ? 1'b1 : (s1_move ? 1'b0 : s1_valid_q);
        s1_hit_d   = s1_hit_q;
        s1_rule_d  = s1_rule_q;
        s1_attr_d  = s1_attr_q;
        if (accept) begin
            s1_hit_d  = match_hit;
            s1_rule_d = match_rule;
            s1_attr_d = match_attr;
        end

        s2_valid_d   = s1_move ? 1'b1 : (rsp_ready_i ? 1'b0 : s2_valid_q);
        s2_hit_d     = s2_hit_q;
        s2_rule_d    = s2_rule_q;
        s2_slave_d   = s2_slave_q;
        s2_cached_d  = s2_cached_q;
        s2_exec_d    = s2_exec_q;
        s2_nonidem_d = s2_nonidem_q;
        if (s1_move) begin
            s2_hit_d     = s1_hit_q;
            s2_rule_d    = s1_hit_q ? s1_rule_q : '0;
            s2_slave_d   = s1_hit_q ? s1_attr_q[4 +: SW] : SW'(NrSlaves);
            s2_cached_d  = s1_hit_q && s1_attr_q[1];
            s2_exec_d    = s1_hit_q && s1_attr_q[2];
            s2_nonidem_d = !s1_hit_q || s1_attr_q[3];
        end

        miss_cnt_d = miss_cnt_q;
        if (s2_valid_q && rsp_ready_i && !s2_hit_q && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_hit_q     <= 1'b0;
            s1_rule_q    <= '0;
            s1_attr_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_hit_q     <= 1'b0;
            s2_rule_q    <= '0;
            s2_slave_q   <= SW'(NrSlaves);
            s2_cached_q  <= 1'b0;
            s2_exec_q    <= 1'b0;
            s2_nonidem_q <= 1'b1;
            miss_cnt_q   <= '0;
        end else begin
            lock_q       <= lock_d;
            cfg_err_q    <= cfg_err_d;
            s1_valid_q   <= s1_valid_d;
            s1_hit_q     <= s1_hit_d;
            s1_rule_q    <= s1_rule_d;
            s1_attr_q    <= s1_attr_d;
            s2_valid_q   <= s2_valid_d;
            s2_hit_q     <= s2_hit_d;
            s2_rule_q    <= s2_rule_d;
            s2_slave_q   <= s2_slave_d;
            s2_cached_q  <= s2_cached_d;
            s2_exec_q    <= s2_exec_d;
            s2_nonidem_q <= s2_nonidem_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign cfg_err_o     = cfg_err_q;
    assign cfg_locked_o  = lock_q;
    assign req_ready_o   = s1_ready;
    assign rsp_valid_o   = s2_valid_q;
    assign rsp_hit_o     = s2_hit_q;
    assign rsp_rule_o    = s2_rule_q;
    assign rsp_slave_o   = s2_slave_q;
    assign rsp_cached_o  = s2_cached_q;
    assign rsp_exec_o    = s2_exec_q;
    assign rsp_nonidem_o = s2_nonidem_q;
    assign miss_cnt_o    = miss_cnt_q;

endmodule

// File: tb/tb_soc_region_map.sv
// Directed bench for soc_region_map: lookups, overlaps, boundaries, a stalled
// stream with a mid-stream attribute write, lock/error handling and reset.
module tb_soc_region_map;
    // Six rules keep index 6 representable on the 3-bit index port.
    localparam int unsigned NR = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [1:0]  cfg_field;
    logic [63:0] cfg_wdata;
    logic        cfg_err, cfg_locked;
    logic        req_valid, req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid, rsp_ready, rsp_hit;
    logic [2:0]  rsp_rule;
    logic [1:0]  rsp_slave;
    logic        rsp_cached, rsp_exec, rsp_nonidem;
    logic [15:0] miss_cnt;
    logic [8:0]  cur_rsp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign cur_rsp = {rsp_hit, rsp_rule, rsp_slave, rsp_cached, rsp_exec, rsp_nonidem};

    soc_region_map #(
        .NrRules    (NR),
        .NrSlaves   (3),
        .AddrWidth  (64),
        .Rule0Base  (64'h8000_0000),
        .Rule0Length(64'h4000_0000),
        .Rule0Attr  (16'h0007)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_we_i     (cfg_we),
        .cfg_idx_i    (cfg_idx),
        .cfg_field_i  (cfg_field),
        .cfg_wdata_i  (cfg_wdata),
        .cfg_err_o    (cfg_err),
        .cfg_locked_o (cfg_locked),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_hit_o    (rsp_hit),
        .rsp_rule_o   (rsp_rule),
        .rsp_slave_o  (rsp_slave),
        .rsp_cached_o (rsp_cached),
        .rsp_exec_o   (rsp_exec),
        .rsp_nonidem_o(rsp_nonidem),
        .miss_cnt_o   (miss_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected response packed as {hit, rule[2:0], slave[1:0], cached, exec, nonidem}.
    task automatic chk_rsp(input string tag, input logic [8:0] exp);
        chk(tag, 64'(cur_rsp), 64'(exp));
    endtask

    task automatic lookup(input logic [63:0] a);
        @(negedge clk);
        chk("lookup.req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = a;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("lookup.no_early_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("lookup.rsp_valid", 64'(rsp_valid), 64'd1);
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [1:0] fld,
                             input logic [63:0] d, input logic exp_err);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_idx   = idx;
        cfg_field = fld;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("cfg.err_pulse", 64'(cfg_err), 64'(exp_err));
        @(negedge clk);
        chk("cfg.err_clear", 64'(cfg_err), 64'd0);
    endtask

    localparam logic [8:0] R0_OLD = 9'b1_000_00_110;
    localparam logic [8:0] R0_NEW = 9'b1_000_01_100;
    localparam logic [8:0] MISS   = 9'b0_000_11_001;

    logic [63:0] s_addr [8];
    logic [8:0]  s_exp  [8];
    int          sent, got, cyc;
    logic        stalled;
    logic [8:0]  held;

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_field = '0;
        cfg_wdata = '0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
        chk_rsp("reset.rsp_fields", MISS & 9'b0_000_11_001);
        chk("reset.miss_cnt", 64'(miss_cnt), 64'd0);
        chk("reset.locked", 64'(cfg_locked), 64'd0);
        chk("reset.cfg_err", 64'(cfg_err), 64'd0);
        chk("reset.req_ready", 64'(req_ready), 64'd1);
        rst_n = 1'b1;

        lookup(64'h8000_1000);
        chk_rsp("dram.hit", R0_OLD);
        lookup(64'h0200_0000);
        chk_rsp("miss.rsp", MISS);
        @(negedge clk);
        chk("miss.cnt1", 64'(miss_cnt), 64'd1);

        cfg_write(3'd1, 2'd0, 64'h0200_0000, 1'b0);
        cfg_write(3'd1, 2'd1, 64'h000C_0000, 1'b0);
        cfg_write(3'd1, 2'd2, 64'h0000_0209, 1'b0);
        lookup(64'h020B_FFFF);
        chk_rsp("r1.last", 9'b1_001_10_001);
        lookup(64'h0200_0000);
        chk_rsp("r1.first", 9'b1_001_10_001);
        lookup(64'h020C_0000);
        chk_rsp("r1.past_end", MISS);
        lookup(64'h01FF_FFFF);
        chk_rsp("r1.below_base", MISS);
        @(negedge clk);
        chk("miss.cnt3", 64'(miss_cnt), 64'd3);

        cfg_write(3'd1, 2'd0, 64'h8000_0000, 1'b0);
        cfg_write(3'd1, 2'd1, 64'h0000_1000, 1'b0);
        cfg_write(3'd1, 2'd2, 64'h0000_0101, 1'b0);
        lookup(64'h8000_0800);
        chk_rsp("overlap.rule0_wins", R0_OLD);
        cfg_write(3'd3, 2'd2, 64'h0000_0001, 1'b0);
        lookup(64'h0000_0000);
        chk_rsp("len0.never", MISS);
        @(negedge clk);
        chk("miss.cnt4", 64'(miss_cnt), 64'd4);

        s_addr[0] = 64'h8000_2000; s_exp[0] = R0_OLD;
        s_addr[1] = 64'h8000_0010; s_exp[1] = R0_OLD;
        s_addr[2] = 64'h0000_1000; s_exp[2] = MISS;
        s_addr[3] = 64'hBFFF_FFFF; s_exp[3] = R0_OLD;
        s_addr[4] = 64'h8000_3000; s_exp[4] = R0_NEW;
        s_addr[5] = 64'hC000_0000; s_exp[5] = MISS;
        s_addr[6] = 64'h8000_0000; s_exp[6] = R0_NEW;
        s_addr[7] = 64'h9000_0000; s_exp[7] = R0_NEW;
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (got < 8 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            cfg_we = 1'b0;
            if (stalled) begin
                chk("stream.stall_valid", 64'(rsp_valid), 64'd1);
                chk("stream.stall_stable", 64'(cur_rsp), 64'(held));
            end
            rsp_ready = (cyc <= 3) ? 1'b0 : 1'($urandom_range(0, 1));
            req_valid = (sent < 8);
            req_addr  = (sent < 8) ? s_addr[sent] : 64'd0;
            #1;
            chk("stream.req_ready", 64'(req_ready), 64'(((sent - got) < 2) || rsp_ready));
            if (req_valid && req_ready && sent == 3) begin
                cfg_we    = 1'b1;
                cfg_idx   = 3'd0;
                cfg_field = 2'd2;
                cfg_wdata = 64'h0000_0103;
            end
            if (rsp_valid && rsp_ready) begin
                chk_rsp($sformatf("stream.rsp%0d", got + 1), s_exp[got]);
                got++;
            end
            stalled = rsp_valid && !rsp_ready;
            held    = cur_rsp;
            if (req_valid && req_ready) sent++;
        end
        chk("stream.all_received", 64'(got), 64'd8);
        @(negedge clk);
        cfg_we    = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("stream.no_extra", 64'(rsp_valid), 64'd0);
        chk("stream.miss_cnt", 64'(miss_cnt), 64'd6);

        cfg_write(3'd2, 2'd0, 64'h1000_0000, 1'b0);
        cfg_write(3'd2, 2'd1, 64'h0000_0100, 1'b0);
        cfg_write(3'd2, 2'd2, 64'h0000_FEF5, 1'b0);
        cfg_write(3'd6, 2'd2, 64'h0000_0001, 1'b1);
        chk("lock.before", 64'(cfg_locked), 64'd0);
        cfg_write(3'd0, 2'd3, 64'h1, 1'b0);
        chk("lock.set", 64'(cfg_locked), 64'd1);
        cfg_write(3'd2, 2'd0, 64'h2000_0000, 1'b1);
        cfg_write(3'd0, 2'd3, 64'h1, 1'b1);
        lookup(64'h1000_0080);
        chk_rsp("lock.table_kept", 9'b1_010_10_010);
        lookup(64'h2000_0080);
        chk_rsp("lock.write_dropped", MISS);
        @(negedge clk);
        chk("lock.miss_cnt", 64'(miss_cnt), 64'd7);

        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 64'h8000_0000;
        @(negedge clk);
        req_addr  = 64'h0000_0000;
        @(negedge clk);
        chk("rst.full_ready", 64'(req_ready), 64'd0);
        chk("rst.full_valid", 64'(rsp_valid), 64'd1);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk_rsp("rst.rsp_fields", MISS);
        chk("rst.locked", 64'(cfg_locked), 64'd0);
        chk("rst.miss_cnt", 64'(miss_cnt), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.dropped", 64'(rsp_valid), 64'd0);
        lookup(64'h1000_0080);
        chk_rsp("rst.table_restored", MISS);
        lookup(64'h8000_3000);
        chk_rsp("rst.rule0_restored", R0_OLD);
        @(negedge clk);
        chk("rst.miss_cnt_after", 64'(miss_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
